// File: rtl/debug_pkg.sv
// Shared constants and state encodings for the debug-link dump transmitter.
package debug_pkg;

    localparam logic [7:0] HEADER_BYTE_DFLT = 8'hA5;
    localparam int NUM_DUMP_WORDS = 32;
    localparam int BYTES_PER_WORD = 4;
    localparam int WORD_IDX_W     = $clog2(NUM_DUMP_WORDS);
    localparam int BYTE_IDX_W     = $clog2(BYTES_PER_WORD);

    typedef enum logic [2:0] {
        FR_IDLE,
        FR_HEADER,
        FR_WORD,
        FR_CHECK,
        FR_FIN
    } frame_state_t;

    typedef enum logic [1:0] {
        BY_IDLE,
        BY_START,
        BY_DATA,
        BY_STOP
    } byte_state_t;

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer, LSB first, CLKS_PER_BIT cycles per bit.
// Latency: tx shows the start bit the cycle after an accepted load.
// Backpressure: load is taken only while ready; ready also covers the last stop cycle so bytes chain with no gap.
module uart_tx_byte
    import debug_pkg::*;
#(
    parameter int CLKS_PER_BIT = 1042
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] data,
    output logic       tx,
    output logic       ready
);

    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    byte_state_t       state, state_nxt;
    logic [BAUD_W-1:0] baud;
    logic [2:0]        bit_cnt;
    logic [7:0]        shreg;
    logic              bit_end;

    assign bit_end = (baud == BAUD_LAST);

    always_comb begin
        state_nxt = state;
        ready     = 1'b0;
        tx        = 1'b1;
        case (state)
            BY_IDLE:  ready = 1'b1;
            BY_START: begin
                tx = 1'b0;
                if (bit_end) state_nxt = BY_DATA;
            end
            BY_DATA: begin
                tx = shreg[0];
                if (bit_end && bit_cnt == 3'd7) state_nxt = BY_STOP;
            end
            BY_STOP: begin
                ready = bit_end;
                if (bit_end) state_nxt = BY_IDLE;
            end
            default: state_nxt = BY_IDLE;
        endcase
        if (load && ready) state_nxt = BY_START;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= BY_IDLE;
            baud    <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
        end else begin
            state <= state_nxt;
            if (load && ready) begin
                baud    <= '0;
                bit_cnt <= '0;
                shreg   <= data;
            end else if (state != BY_IDLE) begin
                baud <= bit_end ? '0 : baud + 1'b1;
                if (state == BY_DATA && bit_end) begin
                    shreg   <= shreg >> 1;
                    bit_cnt <= bit_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/debug_dump_tx.sv
// Serializes a register-file dump frame (header, 32 words MSB byte first, XOR checksum) over UART.
// Latency: start bit on tx the cycle after start; done pulses 1300*CLKS_PER_BIT+1 cycles after start.
// Backpressure: none upstream; start is ignored while busy or during the done cycle.
module debug_dump_tx
    import debug_pkg::*;
#(
    parameter int         CLKS_PER_BIT = 1042,
    parameter logic [7:0] HEADER_BYTE  = HEADER_BYTE_DFLT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [31:0]           rd_data,
    output logic [WORD_IDX_W-1:0] rd_idx,
    output logic                  tx,
    output logic                  busy,
    output logic                  done
);

    localparam logic [BYTE_IDX_W-1:0] BYTE_LAST = BYTE_IDX_W'(BYTES_PER_WORD - 1);

    frame_state_t          state, state_nxt;
    logic [WORD_IDX_W-1:0] word_cnt;
    logic [BYTE_IDX_W-1:0] byte_cnt;
    logic [31:0]           wsr;
    logic [7:0]            csum;
    logic [7:0]            ld_dat;
    logic                  ld;
    logic                  data_ld;
    logic                  byte_rdy;
    logic                  all_loaded;

    // Counters name the next data byte to load; inside WORD they are back at
    // (0,0) only once all 128 data bytes have been handed to the serializer.
    assign all_loaded = (word_cnt == '0) && (byte_cnt == '0);

    always_comb begin
        state_nxt = state;
        ld        = 1'b0;
        data_ld   = 1'b0;
        ld_dat    = HEADER_BYTE;
        busy      = 1'b1;
        done      = 1'b0;
        rd_idx    = '0;
        case (state)
            FR_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    ld        = 1'b1;
                    state_nxt = FR_HEADER;
                end
            end
            FR_HEADER: begin
                if (byte_rdy) begin
                    ld        = 1'b1;
                    data_ld   = 1'b1;
                    ld_dat    = rd_data[31:24];
                    state_nxt = FR_WORD;
                end
            end
            FR_WORD: begin
                rd_idx = word_cnt;
                if (byte_rdy) begin
                    ld = 1'b1;
                    if (all_loaded) begin
                        ld_dat    = csum;
                        state_nxt = FR_CHECK;
                    end else begin
                        data_ld = 1'b1;
                        ld_dat  = (byte_cnt == '0) ? rd_data[31:24] : wsr[31:24];
                    end
                end
            end
            FR_CHECK: begin
                if (byte_rdy) state_nxt = FR_FIN;
            end
            FR_FIN: begin
                busy      = 1'b0;
                done      = 1'b1;
                state_nxt = FR_IDLE;
            end
            default: state_nxt = FR_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= FR_IDLE;
            word_cnt <= '0;
            byte_cnt <= '0;
            wsr      <= '0;
            csum     <= '0;
        end else begin
            state <= state_nxt;
            if (state == FR_IDLE && start) begin
                word_cnt <= '0;
                byte_cnt <= '0;
                csum     <= '0;
            end
            if (data_ld) begin
                csum <= csum ^ ld_dat;
                wsr  <= (byte_cnt == '0) ? {rd_data[23:0], 8'h00} : {wsr[23:0], 8'h00};
                if (byte_cnt == BYTE_LAST) begin
                    byte_cnt <= '0;
                    word_cnt <= word_cnt + 1'b1;
                end else begin
                    byte_cnt <= byte_cnt + 1'b1;
                end
            end
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_ser (
        .clk  (clk),
        .reset(reset),
        .load (ld),
        .data (ld_dat),
        .tx   (tx),
        .ready(byte_rdy)
    );

endmodule
